// File: rtl/shift_cmd_fifo_if.sv
// Handshake bundle for the shift command FIFO: command intake on one side and
// registered shift results on the other.
interface shift_cmd_fifo_if #(
  parameter int DW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_din;
  logic [2:0]    in_shamt;
  logic          in_lr;
  logic          in_al;

  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [DW-1:0] out_src;

  // master produces commands and consumes results; slave is the FIFO itself
  modport master (
    output in_valid, in_din, in_shamt, in_lr, in_al, out_ready,
    input  in_ready, out_valid, out_data, out_src
  );

  modport slave (
    input  in_valid, in_din, in_shamt, in_lr, in_al, out_ready,
    output in_ready, out_valid, out_data, out_src
  );
endinterface

// File: rtl/shift_cmd_fifo.sv
// Command FIFO in front of the combinational 8-bit barrel shifter, with a
// registered result stage so the input and display sides are decoupled.
module shift_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  shift_cmd_fifo_if.slave        bus,
  output logic [DW-1:0]          sh_din,
  output logic [2:0]             sh_shamt,
  output logic                   sh_lr,
  output logic                   sh_al,
  input  logic [DW-1:0]          sh_dout,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef struct packed {
    logic          al;
    logic          lr;
    logic [2:0]    shamt;
    logic [DW-1:0] din;
  } cmd_t;

  cmd_t          mem [DEPTH];
  cmd_t          head;
  cmd_t          incoming;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;

  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);

  // in_ready depends only on occupancy, so a full FIFO never admits a
  // command even when the head is leaving in the same cycle
  assign bus.in_ready = !full;
  assign push         = bus.in_valid && !full;
  assign pop          = !empty && (!bus.out_valid || bus.out_ready);

  assign incoming = '{al: bus.in_al, lr: bus.in_lr, shamt: bus.in_shamt, din: bus.in_din};
  assign head     = mem[rd_ptr];

  always_comb begin
    sh_din   = '0;
    sh_shamt = '0;
    sh_lr    = 1'b0;
    sh_al    = 1'b0;
    if (!empty) begin
      sh_din   = head.din;
      sh_shamt = head.shamt;
      sh_lr    = head.lr;
      sh_al    = head.al;
    end
  end

  // storage needs no reset: the head is masked off whenever count is zero
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= incoming;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // a consumed result with nothing behind it just drops valid; data stays stale
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_src   <= '0;
    end else if (pop) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= sh_dout;
      bus.out_src   <= head.din;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_cmd_fifo.sv
// Self-checking bench for shift_cmd_fifo: a reference shifter feeds sh_dout,
// a scoreboard queue tracks accepted commands, and a vector table covers corners.
module tb_shift_cmd_fifo;

  localparam int DEPTH = 4;
  localparam int DW    = 8;

  typedef struct {
    logic [7:0] din;
    logic [2:0] shamt;
    logic       lr;
    logic       al;
    logic [7:0] expected;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic [7:0] src;
  } sb_t;

  logic                   clk;
  logic                   rst;
  logic [DW-1:0]          sh_din;
  logic [2:0]             sh_shamt;
  logic                   sh_lr;
  logic                   sh_al;
  logic [DW-1:0]          sh_dout;
  logic [$clog2(DEPTH):0] count;

  int  testsRun    = 0;
  int  testsFailed = 0;
  sb_t sb [$];
  vec_t vectors [$];

  shift_cmd_fifo_if #(.DW(DW)) bif ();

  shift_cmd_fifo #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bif.slave),
    .sh_din   (sh_din),
    .sh_shamt (sh_shamt),
    .sh_lr    (sh_lr),
    .sh_al    (sh_al),
    .sh_dout  (sh_dout),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] refShift(input logic [7:0] d, input logic [2:0] s,
                                          input logic l, input logic a);
    if (l)      return d << s;
    else if (a) return 8'($signed(d) >>> s);
    else        return d >> s;
  endfunction

  // stands in for the external combinational barrel shifter
  always_comb sh_dout = refShift(sh_din, sh_shamt, sh_lr, sh_al);

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // scoreboard: record accepted commands, compare every consumed result in order
  always @(negedge clk) begin
    if (!rst) begin
      if (bif.out_valid && bif.out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("sb_underflow", 16'(sb.size()), 16'd1);
        end else begin
          sb_t e;
          e = sb.pop_front();
          checkOutput("sb_data", 16'(bif.out_data), 16'(e.data));
          checkOutput("sb_src", 16'(bif.out_src), 16'(e.src));
        end
      end
      if (bif.in_valid && bif.in_ready) begin
        sb.push_back('{data: refShift(bif.in_din, bif.in_shamt, bif.in_lr, bif.in_al),
                       src: bif.in_din});
      end
    end
  end

  task automatic setCmd(input logic [7:0] d, input logic [2:0] s, input logic l,
                        input logic a);
    bif.in_din   = d;
    bif.in_shamt = s;
    bif.in_lr    = l;
    bif.in_al    = a;
  endtask

  // call just after a rising edge; returns just after the edge that accepted it
  task automatic applyStimulus(input logic [7:0] d, input logic [2:0] s, input logic l,
                               input logic a);
    int waited = 0;
    setCmd(d, s, l, a);
    bif.in_valid = 1'b1;
    @(negedge clk);
    while (!bif.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bif.in_ready) checkOutput("push_accept", 16'(bif.in_ready), 16'd1);
    @(posedge clk);
    #1;
    bif.in_valid = 1'b0;
  endtask

  task automatic waitOutValid(input string name);
    int waited = 0;
    while (!bif.out_valid && waited < 20) begin
      @(posedge clk);
      #1;
      waited++;
    end
    checkOutput(name, 16'(bif.out_valid), 16'd1);
  endtask

  initial begin
    vectors.push_back('{din: 8'h80, shamt: 3'd2, lr: 1'b0, al: 1'b1, expected: 8'hE0});
    vectors.push_back('{din: 8'h80, shamt: 3'd2, lr: 1'b0, al: 1'b0, expected: 8'h20});
    vectors.push_back('{din: 8'hA5, shamt: 3'd7, lr: 1'b1, al: 1'b0, expected: 8'h80});
    vectors.push_back('{din: 8'hA5, shamt: 3'd7, lr: 1'b0, al: 1'b1, expected: 8'hFF});
    vectors.push_back('{din: 8'h5A, shamt: 3'd7, lr: 1'b0, al: 1'b0, expected: 8'h00});
    vectors.push_back('{din: 8'h3C, shamt: 3'd0, lr: 1'b1, al: 1'b0, expected: 8'h3C});
    vectors.push_back('{din: 8'h3C, shamt: 3'd0, lr: 1'b0, al: 1'b1, expected: 8'h3C});

    rst           = 1'b1;
    bif.in_valid  = 1'b0;
    bif.out_ready = 1'b0;
    setCmd(8'h00, 3'd0, 1'b0, 1'b0);
    #1;
    checkOutput("reset_out_valid", 16'(bif.out_valid), 16'd0);
    checkOutput("reset_count", 16'(count), 16'd0);
    checkOutput("reset_out_data", 16'(bif.out_data), 16'd0);
    checkOutput("reset_sh_din", 16'(sh_din), 16'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("reset_in_ready", 16'(bif.in_ready), 16'd1);

    // single command latency: visible on sh_* after the push edge, result one edge later
    bif.out_ready = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(8'h81, 3'd1, 1'b1, 1'b0);
    checkOutput("lat_sh_din", 16'(sh_din), 16'h81);
    checkOutput("lat_count1", 16'(count), 16'd1);
    checkOutput("lat_early_valid", 16'(bif.out_valid), 16'd0);
    @(posedge clk);
    #1;
    checkOutput("lat_out_valid", 16'(bif.out_valid), 16'd1);
    checkOutput("lat_out_data", 16'(bif.out_data), 16'h02);
    checkOutput("lat_out_src", 16'(bif.out_src), 16'h81);
    checkOutput("lat_count0", 16'(count), 16'd0);
    @(posedge clk);
    #1;
    checkOutput("lat_drop_valid", 16'(bif.out_valid), 16'd0);
    checkOutput("lat_stale_data", 16'(bif.out_data), 16'h02);

    foreach (vectors[i]) begin
      applyStimulus(vectors[i].din, vectors[i].shamt, vectors[i].lr, vectors[i].al);
      waitOutValid($sformatf("vec%0d_valid", i));
      checkOutput($sformatf("vec%0d_data", i), 16'(bif.out_data), 16'(vectors[i].expected));
      checkOutput($sformatf("vec%0d_src", i), 16'(bif.out_src), 16'(vectors[i].din));
      @(posedge clk);
      #1;
    end

    // fill under backpressure: one result held, DEPTH queued, sixth refused
    bif.out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) applyStimulus(8'(k), 3'd0, 1'b0, 1'b0);
    checkOutput("fill_count", 16'(count), 16'd4);
    checkOutput("fill_in_ready", 16'(bif.in_ready), 16'd0);
    checkOutput("fill_out_data", 16'(bif.out_data), 16'h01);
    setCmd(8'h06, 3'd0, 1'b0, 1'b0);
    bif.in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      checkOutput("full_hold_count", 16'(count), 16'd4);
      checkOutput("full_hold_data", 16'(bif.out_data), 16'h01);
    end
    bif.in_valid  = 1'b0;
    bif.out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      checkOutput($sformatf("drain%0d_valid", k), 16'(bif.out_valid), 16'd1);
      checkOutput($sformatf("drain%0d_data", k), 16'(bif.out_data), 16'(k));
      @(posedge clk);
      #1;
    end
    checkOutput("drain_done_valid", 16'(bif.out_valid), 16'd0);
    checkOutput("drain_done_count", 16'(count), 16'd0);

    // streaming with simultaneous push and pop at occupancy 2
    bif.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) applyStimulus(8'h40 + 8'(k), 3'(k), 1'b1, 1'b0);
    checkOutput("stream_pre_count", 16'(count), 16'd2);
    bif.out_ready = 1'b1;
    bif.in_valid  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      setCmd(8'h90 + 8'(k * 7), 3'(k), k[0], k[1]);
      @(posedge clk);
      #1;
      checkOutput($sformatf("stream%0d_count", k), 16'(count), 16'd2);
    end
    bif.in_valid = 1'b0;
    for (int k = 0; k < 20 && (count != 0 || bif.out_valid); k++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("stream_drained_count", 16'(count), 16'd0);
    checkOutput("stream_sb_empty", 16'(sb.size()), 16'd0);

    // asynchronous reset between edges with work in flight
    bif.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) applyStimulus(8'hC0 + 8'(k), 3'd1, 1'b0, 1'b1);
    checkOutput("rstmid_pre_count", 16'(count), 16'd3);
    @(negedge clk);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    checkOutput("rstmid_out_valid", 16'(bif.out_valid), 16'd0);
    checkOutput("rstmid_count", 16'(count), 16'd0);
    checkOutput("rstmid_out_data", 16'(bif.out_data), 16'd0);
    checkOutput("rstmid_sh_din", 16'(sh_din), 16'd0);
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bif.out_ready = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(8'hF0, 3'd4, 1'b0, 1'b1);
    waitOutValid("post_rst_valid");
    checkOutput("post_rst_data", 16'(bif.out_data), 16'hFF);
    checkOutput("post_rst_src", 16'(bif.out_src), 16'hF0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("final_sb_empty", 16'(sb.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
